// File: rtl/aven_acc.sv
// Noise-average engine: accumulates 2^LOG2_SYM symbols of N_SC samples, then dumps per-subcarrier average.
// Ports: clk, rst (sync active-low), start, din/din_vld in; dout/dout_vld, busy, ovf_err out. Option: AVEN_ROUND_EN.
module aven_acc #(
  parameter int DW       = 12,
  parameter int N_SC     = 64,
  parameter int LOG2_SYM = 2,
  parameter int AW       = DW + LOG2_SYM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [DW-1:0] din,
  input  logic                 din_vld,
  output logic signed [DW-1:0] dout,
  output logic                 dout_vld,
  output logic                 busy,
  output logic                 ovf_err
);

  localparam int SCW = (N_SC > 1) ? $clog2(N_SC) : 1;
  localparam int SYW = (LOG2_SYM > 0) ? LOG2_SYM : 1;
  localparam logic [SCW-1:0] LAST_SC  = SCW'(N_SC - 1);
  localparam logic [SYW-1:0] LAST_SYM = SYW'((1 << LOG2_SYM) - 1);
`ifdef AVEN_ROUND_EN
  localparam int RND = (LOG2_SYM > 0) ? (1 << (LOG2_SYM - 1)) : 0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DUMP = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [SCW-1:0]     sc_cnt, sc_d, wr_idx;
  logic [SYW-1:0]     sym_cnt, sym_d;
  logic               take, wr_first, rd_vld, ovf_d;

  logic signed [AW-1:0] acc [N_SC];
  logic signed [AW-1:0] din_x, rd;
  logic signed [AW:0]   rnd_sum;
  logic signed [DW-1:0] avg, fixed;

  assign din_x = AW'(din);
  assign rd    = acc[sc_cnt];
  assign busy  = (state != IDLE);

  always_comb begin
    state_d  = state;
    sc_d     = sc_cnt;
    sym_d    = sym_cnt;
    take     = 1'b0;
    ovf_d    = 1'b0;
    rd_vld   = 1'b0;
    wr_idx   = '0;
    wr_first = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          sc_d    = '0;
          sym_d   = '0;
        end
      end
      ACC: begin
        // restart: counters rewind, stay in ACC
        if (start) begin
          sc_d  = '0;
          sym_d = '0;
        end
      end
      DUMP: begin
        rd_vld = 1'b1;
        if (sc_cnt == LAST_SC) begin
          state_d = IDLE;
          sc_d    = '0;
        end else begin
          sc_d = sc_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // a sample with start belongs to the new estimate
    if (din_vld) begin
      if (state == ACC || (state == IDLE && start)) begin
        take     = 1'b1;
        wr_idx   = sc_d;
        wr_first = (sym_d == '0);
        if (sc_d == LAST_SC) begin
          sc_d = '0;
          if (sym_d == LAST_SYM) begin
            sym_d   = '0;
            state_d = DUMP;
          end else begin
            sym_d = sym_d + 1'b1;
          end
        end else begin
          sc_d = sc_d + 1'b1;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
`ifdef AVEN_ROUND_EN
    rnd_sum = (AW+1)'(rd) + (AW+1)'(RND);
`else
    rnd_sum = (AW+1)'(rd);
`endif
    avg   = DW'(rnd_sum >>> LOG2_SYM);
    fixed = (avg == '0) ? DW'(1) : avg;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      sc_cnt   <= '0;
      sym_cnt  <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      state    <= state_d;
      sc_cnt   <= sc_d;
      sym_cnt  <= sym_d;
      dout_vld <= rd_vld;
      ovf_err  <= ovf_d;
      if (rd_vld) dout <= fixed;
    end
  end

  // first symbol overwrites, so no clear pass is needed
  always_ff @(posedge clk) begin
    if (rst && take) begin
      if (wr_first) acc[wr_idx] <= din_x;
      else          acc[wr_idx] <= acc[wr_idx] + din_x;
    end
  end

endmodule

// File: tb/tb_aven_acc.sv
// Testbench for aven_acc: default instance plus LOG2_SYM=0/N_SC=8 instance.
// Scoreboard queues hold expected dout values, popped on dout_vld.
module tb_aven_acc;

  logic clk = 1'b0;
  logic rst;
  logic start, din_vld, start1, din_vld1;
  logic signed [11:0] din, din1;
  logic signed [11:0] dout, dout1;
  logic dout_vld, busy, ovf_err;
  logic dout_vld1, busy1, ovf_err1;

  int n_cmp = 0;
  int n_err = 0;
  int ovf_cnt = 0;
  logic [11:0] q0[$];
  logic [11:0] q1[$];

  always #5 clk = ~clk;

  aven_acc u0 (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_vld(din_vld),
    .dout(dout), .dout_vld(dout_vld), .busy(busy), .ovf_err(ovf_err)
  );

  aven_acc #(.DW(12), .N_SC(8), .LOG2_SYM(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1), .din_vld(din_vld1),
    .dout(dout1), .dout_vld(dout_vld1), .busy(busy1), .ovf_err(ovf_err1)
  );

  always @(negedge clk) begin
    logic [11:0] e;
    if (ovf_err) ovf_cnt++;
    if (dout_vld) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_err++;
        $error("FAIL dout0_unexpected got %0d required none", dout);
      end else begin
        e = q0.pop_front();
        assert (dout === e) else begin
          n_err++;
          $error("FAIL dout0 got %0d required %0d", dout, $signed(e));
        end
      end
    end
    if (dout_vld1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $error("FAIL dout1_unexpected got %0d required none", dout1);
      end else begin
        e = q1.pop_front();
        assert (dout1 === e) else begin
          n_err++;
          $error("FAIL dout1 got %0d required %0d", dout1, $signed(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int req);
    n_cmp++;
    assert (got === req) else begin
      n_err++;
      $error("FAIL %s got %0d required %0d", tag, got, req);
    end
  endtask

  function automatic logic [11:0] model(input int s0, s1, s2, s3);
    int sum;
    logic [11:0] a;
    sum = s0 + s1 + s2 + s3;
`ifdef AVEN_ROUND_EN
    sum = sum + 2;
`endif
    a = 12'(sum >>> 2);
    return (a == 12'd0) ? 12'd1 : a;
  endfunction

  task automatic raw(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      din_vld = 1'b1;
      din     = 12'(v);
      tick();
    end
    din_vld = 1'b0;
  endtask

  task automatic feed(input int s0, s1, s2, s3, input bit gaps, input bit st);
    int s[4];
    logic [11:0] e;
    s = '{s0, s1, s2, s3};
    e = model(s0, s1, s2, s3);
    for (int k = 0; k < 64; k++) q0.push_back(e);
    if (!st) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int y = 0; y < 4; y++) begin
      for (int k = 0; k < 64; k++) begin
        if (gaps) begin
          while ($urandom_range(1, 0) == 1) begin
            din_vld = 1'b0;
            tick();
          end
        end
        din_vld = 1'b1;
        din     = 12'(s[y]);
        if (st && y == 0 && k == 0) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    din_vld = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((q0.size() != 0 || busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk({tag, "_drain_timeout"}, (t < 1000) ? 1 : 0, 1);
    chk({tag, "_busy_done"}, int'(busy), 0);
    chk({tag, "_left"}, q0.size(), 0);
  endtask

  initial begin
    int o;
    int d1[8];
    rst = 1'b0;
    start = 1'b0; din_vld = 1'b0; din = '0;
    start1 = 1'b0; din_vld1 = 1'b0; din1 = '0;
    tick();
    tick();
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_vld", int'(dout_vld), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf_err), 0);
    rst = 1'b1;
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    q0.delete();
    raw(0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;

    feed(100, 100, 100, 100, 1'b0, 1'b1);
    drain("const100");
    feed(4, 8, 12, 16, 1'b0, 1'b0);
    drain("ramp");
    feed(0, 0, 0, 0, 1'b0, 1'b0);
    drain("zero");
    feed(-7, -7, -7, -7, 1'b0, 1'b0);
    drain("neg7");
    feed(1, 2, 2, 2, 1'b0, 1'b0);
    drain("round");
    feed(100, 100, 100, 100, 1'b1, 1'b0);
    drain("gaps");
    chk("ovf_none", ovf_cnt, 0);

    o = ovf_cnt;
    feed(100, 100, 100, 100, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      din_vld = 1'b1;
      din     = 12'sd55;
      start   = (i == 3);
      tick();
    end
    din_vld = 1'b0;
    start   = 1'b0;
    drain("dump_ovf");
    chk("ovf_dump_cnt", ovf_cnt - o, 10);

    o = ovf_cnt;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    tick();
    tick();
    chk("ovf_idle_cnt", ovf_cnt - o, 1);
    chk("idle_busy", int'(busy), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    raw(100, 9);
    feed(50, 50, 50, 50, 1'b0, 1'b1);
    drain("restart");

    feed(100, 100, 100, 100, 1'b0, 1'b0);
    o = 0;
    while (q0.size() > 59 && o < 200) begin
      @(negedge clk);
      o++;
    end
    chk("pre_rst_busy", int'(busy), 1);
    #1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_dump_vld", int'(dout_vld), 0);
    chk("rst_dump_busy", int'(busy), 0);
    q0.delete();
    tick();
    tick();
    chk("rst_dump_idle", int'(busy), 0);
    chk("rst_dump_vld2", int'(dout_vld), 0);

    d1 = '{0, 3, -2, 5, 0, 1, 1, 9};
    for (int i = 0; i < 8; i++)
      q1.push_back((d1[i] == 0) ? 12'd1 : 12'(d1[i]));
    for (int i = 0; i < 8; i++) begin
      din_vld1 = 1'b1;
      din1     = 12'(d1[i]);
      start1   = (i == 0);
      tick();
    end
    din_vld1 = 1'b0;
    start1   = 1'b0;
    o = 0;
    while ((q1.size() != 0 || busy1) && o < 100) begin
      @(negedge clk);
      o++;
    end
    @(negedge clk);
    chk("l0_timeout", (o < 100) ? 1 : 0, 1);
    chk("l0_left", q1.size(), 0);
    chk("l0_busy", int'(busy1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aven_acc.md
Name: aven_acc

Overview:
- Parametrised noise-average engine for channel estimation.
- Accumulates 2^LOG2_SYM consecutive estimated-noise symbols of N_SC samples each into a single accumulator memory, then streams out the per-subcarrier average.
- Replaces the fixed four-symbol, four-FIFO averager with one read-modify-write accumulator, a restartable estimate cycle and error flagging.
- Sits between the noise-estimate stage and the equaliser's sigma2 input.

Parameters:
- DW, 12, signed sample width of din/dout.
- N_SC, 64, samples per symbol (subcarriers); accumulator depth.
- LOG2_SYM, 2, log2 of symbols averaged (NUM_SYM = 2^LOG2_SYM, range 0..4).
- AW, DW+LOG2_SYM, accumulator word width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  synchronous, active-low reset (sampled on clk; 0 = reset).
- start  in  1  one-cycle pulse; begins a new estimate, accumulator cleared.
- din  in  DW  signed noise sample.
- din_vld  in  1  din qualifier.
- dout  out  DW  signed averaged sample, zero replaced by 1.
- dout_vld  out  1  dout qualifier, one sample per cycle during output.
- busy  out  1  high in ACC or DUMP.
- ovf_err  out  1  one-cycle pulse: din_vld dropped (outside ACC).

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, sc_cnt=0, sym_cnt=0, dout=0, dout_vld=0, busy=0, ovf_err=0. Accumulator contents are don't-care; cleared by first-symbol write.
- States:
  - IDLE: start -> ACC. din_vld in IDLE -> ovf_err pulse, sample dropped.
  - ACC: each din_vld cycle at index sc_cnt:
    - sym_cnt==0: acc[sc_cnt] <= sign-extended din (overwrite, no clear pass needed).
    - else: acc[sc_cnt] <= acc[sc_cnt] + din, in AW bits; cannot overflow by construction.
    - sc_cnt wraps N_SC-1 -> 0 and increments sym_cnt.
    - Last sample of symbol NUM_SYM-1 -> DUMP with sc_cnt=0.
    - Cycles without din_vld hold all state; gaps are allowed.
  - DUMP: one read per cycle, sc_cnt 0..N_SC-1; after last read -> IDLE.
    - din_vld in DUMP -> ovf_err, sample dropped.
- Output arithmetic:
  - avg = acc >>> LOG2_SYM (arithmetic shift, truncation toward -inf), low DW bits.
  - If avg==0, dout=1; else dout=avg.
  - LOG2_SYM=0: pass-through with zero-fix.
- Latency: dout_vld asserts 1 cycle after the DUMP read of index k, so k=0 appears the cycle after entering DUMP. Exactly N_SC consecutive dout_vld cycles, in subcarrier order. dout holds its last value when dout_vld=0.
- busy=1 from the cycle after start through the cycle of the last DUMP read.
- Simultaneous events:
  - start in ACC: abort, sym_cnt=sc_cnt=0, stay ACC (restart); a same-cycle din_vld is taken as sample 0 of the new estimate.
  - start in DUMP: ignored; dump completes.
  - start in IDLE with din_vld: din is sample 0.
- Reset mid-ACC or mid-DUMP: immediate IDLE, dout_vld=0 next cycle, partial results discarded.
- Accumulator: a register array or inferred single-port RAM with a combinational read; read-modify-write completes in one cycle, so back-to-back din_vld is supported.

Optional Feature:
- Macro AVEN_ROUND_EN.
  - Defined (LOG2_SYM>0): avg = (acc + 2^(LOG2_SYM-1)) >>> LOG2_SYM, round-half-up, computed in AW+1 bits then truncated to DW; zero-fix still applied.
  - Undefined: truncating shift as above.
- Latency and all handshakes are identical either way.

Test Plan:
- Defaults, start, 256 samples all =100 -> 64 dout_vld cycles, dout=100 each, busy drops after last; ovf_err never.
- Subcarrier k gets 4,8,12,16 across symbols 0..3 (all k) -> dout=10 for all 64.
- All-zero input (256 samples) -> dout=1 x64. All -7 -> dout=-7 x64. Sequence 1,2,2,2 -> dout=1 without AVEN_ROUND_EN, 2 with it.
- Random din_vld gaps (~50% duty) on the first case -> identical output. din_vld asserted during DUMP -> ovf_err one pulse per sample, dout stream unchanged.
- start after 100 samples, then 256 samples of 50 -> dout=50 x64 (first 100 discarded). rst=0 for 1 cycle mid-DUMP -> dout_vld=0 next cycle, busy=0, IDLE.
- LOG2_SYM=0, N_SC=8: samples 0,3,-2,5,0,1,1,9 -> dout 1,3,-2,5,1,1,1,9.
